placar_truco: RTL and testbench
===============================

Name: placar_truco

Overview:
- Score keeper that consumes the per-hand result stream from the vaza distribution stage.
- Input is the 4-bit points word S plus the winner bit V. The word is non-zero for one cycle when a hand closes.
- Accumulates both teams' game scores up to the target and flags "mão de onze" / "mão de ferro".
- Declares the game winner and counts games won. The NewGame input restarts scoring.

Parameters:
TARGET, 12, points needed to win a game (1..31; score registers are 5 bits)
GW, 4, width of the games-won counters

Ports:
Clk  input  1  system clock, rising-edge
Clr_n  input  1  reset, asynchronous, active-low; clears every register
S  input  4  hand points; non-zero for one cycle = hand result valid
V  input  1  hand winner, sampled only when S != 0; 0 = team A, 1 = team B
NewGame  input  1  synchronous request to zero both scores and enter PLAY
ScoreA  output  5  team A game score
ScoreB  output  5  team B game score
HandAck  output  1  one-cycle pulse, the cycle after an accepted hand result
MaoOnze  output  1  PLAY and exactly one score equals TARGET-1
MaoOnzeTeam  output  1  team at TARGET-1 (0 = A, 1 = B); 0 when MaoOnze = 0
MaoFerro  output  1  PLAY and both scores equal TARGET-1
GameOver  output  1  high while in state OVER
Winner  output  1  game winner (0 = A, 1 = B); valid while GameOver = 1, else 0
GamesA  output  GW  games won by team A, saturating
GamesB  output  GW  games won by team B, saturating

Behaviour:
- Reset (Clr_n = 0, asynchronous):
  - State = PLAY.
  - All score, counter and flag registers = 0; every output = 0.
  - Takes effect mid-hand or mid-game, with no residual ack.
- FSM states:
  - PLAY: accepting hand results.
  - OVER: game decided.
- PLAY, rising edge with S != 0 and NewGame = 0 (hand accepted):
  - The winning team's score (by V) becomes min(score + S, TARGET). Compute the sum at 6 bits, then saturate.
  - HandAck = 1 for exactly the following cycle.
  - If the saturated result equals TARGET, on the same edge:
    - state goes to OVER;
    - Winner = V;
    - the matching Games counter increments, holding at 2^GW-1.
  - Latency: S/V sampled at edge k. ScoreX, HandAck, GameOver, Winner and Games update at edge k, visible in cycle k+1.
- Any non-zero S is added as-is; no validation of the {1,3,6,9,12} set.
- Only one team scores per hand; the loser's score is unchanged.
- S = 0: no change, HandAck = 0.
- OVER:
  - S is ignored and no HandAck is produced.
  - Scores, Winner and GameOver hold until NewGame.
- NewGame = 1 at an edge, in either state:
  - ScoreA = ScoreB = 0, Winner = 0, state = PLAY.
  - Games counters are kept.
  - HandAck is forced to 0 next cycle.
  - If S != 0 on the same edge, NewGame wins and the hand is dropped.
- NewGame held for several cycles: scores stay 0 and hand results are dropped each cycle it is high.
- MaoOnze, MaoOnzeTeam and MaoFerro are decoded combinationally from the registered scores and state. They are never high in OVER.
- Back-to-back hand results in consecutive cycles are legal; each is accepted and produces its own HandAck.
- A score already at TARGET-1 that receives S = 12 saturates to TARGET.

Test Plan:
- Reset then S=1,V=0 for one cycle → next cycle ScoreA=1, ScoreB=0, HandAck=1 for one cycle; GameOver=0.
- Scores A=10, B=11 → MaoOnze=1, MaoOnzeTeam=1, MaoFerro=0. Then S=1,V=0 → A=11 → MaoFerro=1, MaoOnze=0.
- A=9, then S=6,V=0 → ScoreA=12 (saturated, not 15), GameOver=1, Winner=0, GamesA=1. A following S=3,V=1 → ScoreB unchanged, no HandAck.
- In OVER, pulse NewGame → next cycle ScoreA=ScoreB=0, GameOver=0, GamesA still 1. NewGame together with S=3 → S dropped, scores 0, HandAck=0.
- Consecutive cycles S=3,V=1 then S=1,V=1 → ScoreB=3 then 4, HandAck high two cycles.
- GamesB preloaded to 15 (GW=4) by playing 15 games, then B wins again → GamesB holds 15. Assert Clr_n=0 mid-game with ScoreA=7 → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/placar_truco.sv
// rtl/placar_truco.sv - truco game score keeper with mao de onze/ferro flags and games-won counters
//
// Purpose: accumulates per-hand points for teams A and B up to TARGET, declares the
// game winner, counts games won (saturating) and flags mao de onze / mao de ferro.
// Ports:
//   Clk, Clr_n        clock (rising edge), asynchronous active-low reset
//   S, V              hand points (non-zero = valid for one cycle), hand winner (0 = A, 1 = B)
//   NewGame           synchronous restart: zero both scores, enter PLAY, keep games counters
//   ScoreA, ScoreB    current game scores
//   HandAck           one-cycle pulse after an accepted hand result
//   MaoOnze/MaoOnzeTeam/MaoFerro  decoded from registered scores while in PLAY
//   GameOver, Winner  game decided and its winner
//   GamesA, GamesB    games won per team, saturating
module placar_truco #(
  parameter int TARGET = 12,
  parameter int GW     = 4
) (
  input  logic          Clk,
  input  logic          Clr_n,
  input  logic [3:0]    S,
  input  logic          V,
  input  logic          NewGame,
  output logic [4:0]    ScoreA,
  output logic [4:0]    ScoreB,
  output logic          HandAck,
  output logic          MaoOnze,
  output logic          MaoOnzeTeam,
  output logic          MaoFerro,
  output logic          GameOver,
  output logic          Winner,
  output logic [GW-1:0] GamesA,
  output logic [GW-1:0] GamesB
);

  typedef enum logic {PLAY = 1'b0, OVER = 1'b1} state_t;

  localparam logic [4:0]    TGT     = 5'(TARGET);
  localparam logic [4:0]    TGT_M1  = 5'(TARGET - 1);
  localparam logic [GW-1:0] GAMES_MAX = {GW{1'b1}};

  state_t        state, state_nx;
  logic [4:0]    score_a, score_b, score_a_nx, score_b_nx;
  logic          ack, ack_nx;
  logic          winner, winner_nx;
  logic [GW-1:0] games_a, games_b, games_a_nx, games_b_nx;

  logic [4:0]    base;
  logic [5:0]    sum;
  logic [4:0]    sat;
  logic          a_m1, b_m1;

  // Sum at 6 bits so 31 + 15 cannot wrap before saturation.
  always_comb begin
    base = V ? score_b : score_a;
    sum  = {1'b0, base} + {2'b00, S};
    sat  = (sum >= {1'b0, TGT}) ? TGT : sum[4:0];
  end

  always_comb begin
    state_nx   = state;
    score_a_nx = score_a;
    score_b_nx = score_b;
    ack_nx     = 1'b0;
    winner_nx  = winner;
    games_a_nx = games_a;
    games_b_nx = games_b;
    if (NewGame) begin
      // NewGame has priority over a hand arriving on the same edge.
      state_nx   = PLAY;
      score_a_nx = 5'd0;
      score_b_nx = 5'd0;
      winner_nx  = 1'b0;
    end else if (state == PLAY && S != 4'd0) begin
      ack_nx = 1'b1;
      if (V) score_b_nx = sat;
      else   score_a_nx = sat;
      if (sat == TGT) begin
        state_nx  = OVER;
        winner_nx = V;
        if (V) begin
          if (games_b != GAMES_MAX) games_b_nx = games_b + 1'b1;
        end else begin
          if (games_a != GAMES_MAX) games_a_nx = games_a + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      state   <= PLAY;
      score_a <= 5'd0;
      score_b <= 5'd0;
      ack     <= 1'b0;
      winner  <= 1'b0;
      games_a <= '0;
      games_b <= '0;
    end else begin
      state   <= state_nx;
      score_a <= score_a_nx;
      score_b <= score_b_nx;
      ack     <= ack_nx;
      winner  <= winner_nx;
      games_a <= games_a_nx;
      games_b <= games_b_nx;
    end
  end

  always_comb begin
    a_m1        = (score_a == TGT_M1);
    b_m1        = (score_b == TGT_M1);
    ScoreA      = score_a;
    ScoreB      = score_b;
    HandAck     = ack;
    GameOver    = (state == OVER);
    Winner      = (state == OVER) & winner;
    GamesA      = games_a;
    GamesB      = games_b;
    MaoOnze     = (state == PLAY) & (a_m1 ^ b_m1);
    MaoOnzeTeam = (state == PLAY) & (a_m1 ^ b_m1) & b_m1;
    MaoFerro    = (state == PLAY) & a_m1 & b_m1;
  end

endmodule

// File: tb/tb_placar_truco.sv
// tb/tb_placar_truco.sv - scoreboard testbench for placar_truco
module tb_placar_truco;

  logic       Clk = 1'b0;
  logic       Clr_n = 1'b0;
  logic [3:0] S = 4'd0;
  logic       V = 1'b0;
  logic       NewGame = 1'b0;
  logic [4:0] ScoreA, ScoreB;
  logic       HandAck, MaoOnze, MaoOnzeTeam, MaoFerro, GameOver, Winner;
  logic [3:0] GamesA, GamesB;

  placar_truco #(.TARGET(12), .GW(4)) dut (
    .Clk(Clk), .Clr_n(Clr_n), .S(S), .V(V), .NewGame(NewGame),
    .ScoreA(ScoreA), .ScoreB(ScoreB), .HandAck(HandAck),
    .MaoOnze(MaoOnze), .MaoOnzeTeam(MaoOnzeTeam), .MaoFerro(MaoFerro),
    .GameOver(GameOver), .Winner(Winner), .GamesA(GamesA), .GamesB(GamesB)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [4:0] sa;
    logic [4:0] sb;
    logic       go;
    logic       win;
    logic [3:0] ga;
    logic [3:0] gb;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state
  int ma = 0, mb = 0, mga = 0, mgb = 0;
  logic mover = 1'b0, mwin = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  // Monitor: every HandAck cycle must match the oldest queued expectation.
  always @(negedge Clk) begin
    if (Clr_n && HandAck) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_handack actual=1 expected=0");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ack_scoreA", ScoreA, e.sa);
        chk("ack_scoreB", ScoreB, e.sb);
        chk("ack_gameover", GameOver, e.go);
        chk("ack_winner", Winner, e.win);
        chk("ack_gamesA", GamesA, e.ga);
        chk("ack_gamesB", GamesB, e.gb);
      end
    end
  end

  // One clock: drive inputs at negedge, update the model, return 1ns after the edge.
  task automatic cycle(input int s, input logic v, input logic ng);
    int sum;
    exp_t e;
    @(negedge Clk);
    S = 4'(s);
    V = v;
    NewGame = ng;
    if (ng) begin
      ma = 0; mb = 0; mover = 1'b0; mwin = 1'b0;
    end else if (!mover && s != 0) begin
      sum = (v ? mb : ma) + s;
      if (sum > 12) sum = 12;
      if (v) mb = sum; else ma = sum;
      if (sum == 12) begin
        mover = 1'b1;
        mwin = v;
        if (v) begin if (mgb != 15) mgb++; end
        else   begin if (mga != 15) mga++; end
      end
      e.sa = 5'(ma); e.sb = 5'(mb); e.go = mover; e.win = mwin;
      e.ga = 4'(mga); e.gb = 4'(mgb);
      exp_q.push_back(e);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    cycle(0, 1'b0, 1'b0);
  endtask

  task automatic check_state(input string tag);
    logic a1, b1;
    a1 = (ma == 11);
    b1 = (mb == 11);
    chk({tag, "_scoreA"}, ScoreA, ma);
    chk({tag, "_scoreB"}, ScoreB, mb);
    chk({tag, "_gameover"}, GameOver, mover);
    chk({tag, "_winner"}, Winner, mover & mwin);
    chk({tag, "_maoonze"}, MaoOnze, !mover && (a1 != b1));
    chk({tag, "_maoonzeteam"}, MaoOnzeTeam, !mover && (a1 != b1) && b1);
    chk({tag, "_maoferro"}, MaoFerro, !mover && a1 && b1);
    chk({tag, "_gamesA"}, GamesA, mga);
    chk({tag, "_gamesB"}, GamesB, mgb);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_scoreA", ScoreA, 0);
    chk("rst_handack", HandAck, 0);
    chk("rst_gameover", GameOver, 0);
    @(negedge Clk);
    Clr_n = 1'b1;
    idle();
    check_state("post_reset");

    // First hand: A gets 1
    cycle(1, 1'b0, 1'b0);
    chk("first_ack", HandAck, 1);
    chk("first_scoreA", ScoreA, 1);
    idle();
    chk("ack_one_cycle", HandAck, 0);

    // A=10, B=11 -> mao de onze for B
    cycle(9, 1'b0, 1'b0);
    cycle(11, 1'b1, 1'b0);
    idle();
    check_state("onze_b");
    chk("onze_flag", MaoOnze, 1);
    chk("onze_team", MaoOnzeTeam, 1);
    // A to 11 -> mao de ferro
    cycle(1, 1'b0, 1'b0);
    idle();
    check_state("ferro");
    chk("ferro_flag", MaoFerro, 1);
    chk("ferro_onze", MaoOnze, 0);

    // A=9 then S=6 saturates to 12, game over
    cycle(0, 1'b0, 1'b1);
    cycle(9, 1'b0, 1'b0);
    cycle(6, 1'b0, 1'b0);
    idle();
    check_state("win_a");
    chk("sat_scoreA", ScoreA, 12);
    chk("win_gamesA", GamesA, 1);
    // Ignored in OVER
    cycle(3, 1'b1, 1'b0);
    chk("over_no_ack", HandAck, 0);
    check_state("over_hold");

    // NewGame in OVER, then NewGame with a simultaneous hand
    cycle(0, 1'b0, 1'b1);
    check_state("newgame");
    cycle(3, 1'b0, 1'b1);
    chk("ng_drop_ack", HandAck, 0);
    check_state("ng_drop");
    cycle(5, 1'b1, 1'b1);
    check_state("ng_held");

    // Back-to-back hands for B
    cycle(3, 1'b1, 1'b0);
    chk("b2b_ack1", HandAck, 1);
    chk("b2b_scoreB1", ScoreB, 3);
    cycle(1, 1'b1, 1'b0);
    chk("b2b_ack2", HandAck, 1);
    chk("b2b_scoreB2", ScoreB, 4);
    idle();

    // A at 11 receiving 12 saturates to 12
    cycle(0, 1'b0, 1'b1);
    cycle(11, 1'b0, 1'b0);
    cycle(12, 1'b0, 1'b0);
    idle();
    check_state("sat_12");

    // B wins 16 games; counter saturates at 15
    for (int g = 0; g < 16; g++) begin
      cycle(0, 1'b0, 1'b1);
      cycle(12, 1'b1, 1'b0);
    end
    idle();
    check_state("gamesB_sat");
    chk("gamesB_max", GamesB, 15);

    // Asynchronous reset mid-game
    cycle(0, 1'b0, 1'b1);
    cycle(7, 1'b0, 1'b0);
    idle();
    chk("pre_rst_scoreA", ScoreA, 7);
    #2;
    Clr_n = 1'b0;
    #1;
    ma = 0; mb = 0; mga = 0; mgb = 0; mover = 1'b0; mwin = 1'b0;
    check_state("async_rst");
    chk("async_rst_ack", HandAck, 0);
    @(negedge Clk);
    Clr_n = 1'b1;
    idle();
    idle();

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
